// File: rtl/id_stage.sv
// id_stage: instruction decode with register file, immediate extension,
// branch resolution and the ID/EX pipeline register (freeze/flush).
module id_stage #(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic [31:0] instr,
  input  logic [31:0] pc_in,
  input  logic        wb_en,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_value,
  output logic [4:0]  src1,
  output logic [4:0]  src2,
  output logic        two_src,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic [31:0] pc_out,
  output logic [31:0] val1,
  output logic [31:0] val2,
  output logic [31:0] st_val,
  output logic [4:0]  dest,
  output logic [3:0]  exe_cmd,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic        wb_en_out
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] st;
    logic [4:0]  dest;
    logic [3:0]  cmd;
    logic        mr;
    logic        mw;
    logic        wb;
  } idex_t;

  localparam idex_t BUBBLE = '{
    pc: 32'h0, v1: 32'h0, v2: 32'h0, st: 32'h0,
    dest: 5'h0, cmd: 4'hF, mr: 1'b0, mw: 1'b0, wb: 1'b0
  };

  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_NOR  = 6'd7;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_SLA  = 6'd9;
  localparam logic [5:0] OP_SLL  = 6'd10;
  localparam logic [5:0] OP_SRA  = 6'd11;
  localparam logic [5:0] OP_SRL  = 6'd12;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_SUBI = 6'd33;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sext;
  logic [31:0] rs_v, rt_v;
  logic [31:0] regs_q [NREG];
  idex_t       idex_q, idex_d, dec;

  logic [3:0] cmd;
  logic       rtype, imm_wb, ld, st, bez, bne, jmp;

  assign op   = instr[31:26];
  assign rs   = instr[25:21];
  assign rt   = instr[20:16];
  assign rd   = instr[15:11];
  assign sext = {{16{instr[15]}}, instr[15:0]};

  always_comb begin
    cmd    = 4'hF;
    rtype  = 1'b0;
    imm_wb = 1'b0;
    ld     = 1'b0;
    st     = 1'b0;
    bez    = 1'b0;
    bne    = 1'b0;
    jmp    = 1'b0;
    unique case (op)
      OP_ADD:  begin cmd = 4'h0; rtype = 1'b1; end
      OP_SUB:  begin cmd = 4'h2; rtype = 1'b1; end
      OP_AND:  begin cmd = 4'h4; rtype = 1'b1; end
      OP_OR:   begin cmd = 4'h5; rtype = 1'b1; end
      OP_NOR:  begin cmd = 4'h6; rtype = 1'b1; end
      OP_XOR:  begin cmd = 4'h7; rtype = 1'b1; end
      OP_SLA,
      OP_SLL:  begin cmd = 4'h8; rtype = 1'b1; end
      OP_SRA:  begin cmd = 4'h9; rtype = 1'b1; end
      OP_SRL:  begin cmd = 4'hA; rtype = 1'b1; end
      OP_ADDI: begin cmd = 4'h0; imm_wb = 1'b1; end
      OP_SUBI: begin cmd = 4'h2; imm_wb = 1'b1; end
      OP_LD:   begin cmd = 4'h0; ld = 1'b1; end
      OP_ST:   begin cmd = 4'h0; st = 1'b1; end
      OP_BEZ:  bez = 1'b1;
      OP_BNE:  bne = 1'b1;
      OP_JMP:  jmp = 1'b1;
      default: ;
    endcase
  end

  // Reads bypass the write-back port so decode never sees a stale value.
  assign rs_v = (rs == 5'd0 || int'(rs) >= NREG) ? 32'h0 :
                (wb_en && wb_dest == rs) ? wb_value : regs_q[rs];
  assign rt_v = (rt == 5'd0 || int'(rt) >= NREG) ? 32'h0 :
                (wb_en && wb_dest == rt) ? wb_value : regs_q[rt];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: 32'h0};
    end else if (wb_en && wb_dest != 5'd0 && int'(wb_dest) < NREG) begin
      regs_q[wb_dest] <= wb_value;
    end
  end

  assign src1         = rs;
  assign src2         = rt;
  assign two_src      = rtype | st | bne;
  assign branch_addr  = pc_in + {sext[29:0], 2'b00};
  assign branch_taken = ~freeze &
                        (jmp | (bez & (rs_v == 32'h0)) | (bne & (rs_v != rt_v)));

  always_comb begin
    dec      = BUBBLE;
    dec.pc   = pc_in;
    dec.v1   = rs_v;
    dec.v2   = rtype ? rt_v : sext;
    dec.st   = rt_v;
    dec.cmd  = cmd;
    dec.mr   = ld;
    dec.mw   = st;
    dec.wb   = rtype | imm_wb | ld;
    dec.dest = rtype ? rd : (imm_wb | ld) ? rt : 5'd0;
  end

  always_comb begin
    idex_d = dec;
    if (flush)       idex_d = BUBBLE;
    else if (freeze) idex_d = idex_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_q <= BUBBLE;
    else     idex_q <= idex_d;
  end

  assign pc_out    = idex_q.pc;
  assign val1      = idex_q.v1;
  assign val2      = idex_q.v2;
  assign st_val    = idex_q.st;
  assign dest      = idex_q.dest;
  assign exe_cmd   = idex_q.cmd;
  assign mem_r_en  = idex_q.mr;
  assign mem_w_en  = idex_q.mw;
  assign wb_en_out = idex_q.wb;

endmodule
